// File: rtl/axi_lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave_if
// Purpose  : AXI-Lite bus bundle between the command handler (master) and the
//            control/status register bank (slave).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals  : axi_aw*  write address channel   (awaddr, awvalid / awready)
//            axi_w*   write data channel      (wdata, wstrb, wvalid / wready)
//            axi_b*   write response channel  (bresp, bvalid / bready)
//            axi_ar*  read address channel    (araddr, arvalid / arready)
//            axi_r*   read data channel       (rdata, rresp, rvalid / rready)
// ============================================================================
interface axi_lite_reg_slave_if #(
   parameter int ADDR_W = 15
) ();
   logic [ADDR_W-1:0] axi_awaddr;
   logic              axi_awvalid;
   logic              axi_awready;
   logic [31:0]       axi_wdata;
   logic [3:0]        axi_wstrb;
   logic              axi_wvalid;
   logic              axi_wready;
   logic [1:0]        axi_bresp;
   logic              axi_bvalid;
   logic              axi_bready;
   logic [ADDR_W-1:0] axi_araddr;
   logic              axi_arvalid;
   logic              axi_arready;
   logic [31:0]       axi_rdata;
   logic [1:0]        axi_rresp;
   logic              axi_rvalid;
   logic              axi_rready;

   modport master (
      output axi_awaddr, axi_awvalid, input axi_awready,
      output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
      input  axi_bresp, axi_bvalid, output axi_bready,
      output axi_araddr, axi_arvalid, input axi_arready,
      input  axi_rdata, axi_rresp, axi_rvalid, output axi_rready
   );

   modport slave (
      input  axi_awaddr, axi_awvalid, output axi_awready,
      input  axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
      output axi_bresp, axi_bvalid, input axi_bready,
      input  axi_araddr, axi_arvalid, output axi_arready,
      output axi_rdata, axi_rresp, axi_rvalid, input axi_rready
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Purpose  : AXI-Lite responder for the control/status register bank. Serves
//            REG_WRITE / REG_READ transactions from the USB command handler.
//            Independent write and read channels, one outstanding each.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports    : clk        sole clock
//            rstn       asynchronous active-low reset
//            axi        AXI-Lite slave modport (axi_lite_reg_slave_if)
//            status_in  live status word, sampled when a read is accepted
//            ctrl_out   CTRL register contents
//            pulse_out  one-cycle strobes produced by PULSE writes
// Map      : 0x00 VERSION RO | 0x04 STATUS RO | 0x08 SCRATCH RW |
//            0x0C CTRL RW    | 0x10 PULSE WO (reads 0) | 0x14 WR_COUNT RO
// Config   : AXIL_SLVERR_EN  when defined, unmapped accesses return SLVERR
//                            (reads return 32'hDEADBEEF); otherwise OKAY/0.
// ============================================================================
module axi_lite_reg_slave #(
   parameter int          ADDR_W   = 15,
   parameter logic [31:0] VERSION  = 32'h2025_1122,
   parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
   input  wire logic           clk,
   input  wire logic           rstn,
   axi_lite_reg_slave_if.slave axi,
   input  wire logic [31:0]    status_in,
   output logic [31:0]         ctrl_out,
   output logic [31:0]         pulse_out
);

   localparam int IDX_W = ADDR_W - 2;

   localparam logic [IDX_W-1:0] c_idx_version  = IDX_W'(0);
   localparam logic [IDX_W-1:0] c_idx_status   = IDX_W'(1);
   localparam logic [IDX_W-1:0] c_idx_scratch  = IDX_W'(2);
   localparam logic [IDX_W-1:0] c_idx_ctrl     = IDX_W'(3);
   localparam logic [IDX_W-1:0] c_idx_pulse    = IDX_W'(4);
   localparam logic [IDX_W-1:0] c_idx_wr_count = IDX_W'(5);

   localparam logic [1:0] c_resp_okay = 2'b00;
`ifdef AXIL_SLVERR_EN
   localparam logic [1:0]  c_resp_unmapped  = 2'b10;
   localparam logic [31:0] c_rdata_unmapped = 32'hDEAD_BEEF;
`else
   localparam logic [1:0]  c_resp_unmapped  = 2'b00;
   localparam logic [31:0] c_rdata_unmapped = 32'h0000_0000;
`endif

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wstate_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   // ------------------------------------------------------------------------
   // Ready gating: the bus must see all readies low while in reset and high
   // only once the first clock edge after release has occurred.
   // ------------------------------------------------------------------------
   logic r_ready_en;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Register bank state
   // ------------------------------------------------------------------------
   logic [31:0] r_scratch;
   logic [31:0] r_ctrl;
   logic [31:0] r_pulse;
   logic [31:0] r_wr_count;

   // ------------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------------
   wstate_t          r_wstate;
   wstate_t          w_wstate_nxt;
   logic             r_aw_held;
   logic             r_w_held;
   logic [IDX_W-1:0] r_awidx;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic [1:0]       r_bresp;

   logic             w_awready;
   logic             w_wready;
   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_commit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wstate <= W_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
      end
   end

   // Commit fires in the cycle where both AW and W are either already held
   // or handshaking right now, so AW and W may arrive in either order.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_awready    = 1'b0;
      w_wready     = 1'b0;
      w_aw_hs      = 1'b0;
      w_w_hs       = 1'b0;
      w_commit     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_awready = r_ready_en && !r_aw_held;
            w_wready  = r_ready_en && !r_w_held;
            w_aw_hs   = axi.axi_awvalid && w_awready;
            w_w_hs    = axi.axi_wvalid  && w_wready;
            w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
            if (w_commit) begin
               w_wstate_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (axi.axi_bready) begin
               w_wstate_nxt = W_IDLE;
            end
         end
         default: begin
            w_wstate_nxt = W_IDLE;
         end
      endcase
   end

   // Commit operands come from the holding registers when that half arrived
   // earlier, otherwise straight from the bus.
   logic [IDX_W-1:0] w_cmt_idx;
   logic [31:0]      w_cmt_data;
   logic [3:0]       w_cmt_strb;
   logic [31:0]      w_cmt_mask;
   logic             w_cmt_mapped;

   assign w_cmt_idx    = r_aw_held ? r_awidx : axi.axi_awaddr[ADDR_W-1:2];
   assign w_cmt_data   = r_w_held  ? r_wdata : axi.axi_wdata;
   assign w_cmt_strb   = r_w_held  ? r_wstrb : axi.axi_wstrb;
   assign w_cmt_mask   = {{8{w_cmt_strb[3]}}, {8{w_cmt_strb[2]}},
                          {8{w_cmt_strb[1]}}, {8{w_cmt_strb[0]}}};
   // The map is contiguous from index 0, so one compare covers it.
   assign w_cmt_mapped = (w_cmt_idx <= c_idx_wr_count);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awidx    <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bresp    <= c_resp_okay;
         r_scratch  <= '0;
         r_ctrl     <= CTRL_RST;
         r_pulse    <= '0;
         r_wr_count <= '0;
      end else begin
         // PULSE strobes live for exactly one cycle after the commit.
         r_pulse <= '0;
         if (w_commit) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_wr_count <= r_wr_count + 32'd1;
            r_bresp    <= w_cmt_mapped ? c_resp_okay : c_resp_unmapped;
            case (w_cmt_idx)
               c_idx_scratch: r_scratch <= (r_scratch & ~w_cmt_mask) | (w_cmt_data & w_cmt_mask);
               c_idx_ctrl:    r_ctrl    <= (r_ctrl    & ~w_cmt_mask) | (w_cmt_data & w_cmt_mask);
               c_idx_pulse:   r_pulse   <= w_cmt_data & w_cmt_mask;
               default:       ; // RO and unmapped writes are accepted silently
            endcase
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_awidx   <= axi.axi_awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_wdata  <= axi.axi_wdata;
               r_wstrb  <= axi.axi_wstrb;
            end
         end
      end
   end

   assign axi.axi_awready = w_awready;
   assign axi.axi_wready  = w_wready;
   assign axi.axi_bvalid  = (r_wstate == W_RESP);
   assign axi.axi_bresp   = r_bresp;

   // ------------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------------
   rstate_t          r_rstate;
   rstate_t          w_rstate_nxt;
   logic [31:0]      r_rdata;
   logic [1:0]       r_rresp;

   logic             w_arready;
   logic             w_ar_hs;
   logic [IDX_W-1:0] w_ridx;
   logic [31:0]      w_rd_data;
   logic             w_rd_mapped;

   assign w_ridx = axi.axi_araddr[ADDR_W-1:2];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rstate <= R_IDLE;
      end else begin
         r_rstate <= w_rstate_nxt;
      end
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_arready    = 1'b0;
      w_ar_hs      = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_arready = r_ready_en;
            w_ar_hs   = axi.axi_arvalid && w_arready;
            if (w_ar_hs) begin
               w_rstate_nxt = R_DATA;
            end
         end
         R_DATA: begin
            if (axi.axi_rready) begin
               w_rstate_nxt = R_IDLE;
            end
         end
         default: begin
            w_rstate_nxt = R_IDLE;
         end
      endcase
   end

   // Read mux samples the current register values, so a read accepted in the
   // same cycle as a write commit sees the pre-write contents.
   always_comb begin
      w_rd_data   = c_rdata_unmapped;
      w_rd_mapped = 1'b1;
      case (w_ridx)
         c_idx_version:  w_rd_data = VERSION;
         c_idx_status:   w_rd_data = status_in;
         c_idx_scratch:  w_rd_data = r_scratch;
         c_idx_ctrl:     w_rd_data = r_ctrl;
         c_idx_pulse:    w_rd_data = '0;
         c_idx_wr_count: w_rd_data = r_wr_count;
         default: begin
            w_rd_data   = c_rdata_unmapped;
            w_rd_mapped = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rdata <= '0;
         r_rresp <= c_resp_okay;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_data;
         r_rresp <= w_rd_mapped ? c_resp_okay : c_resp_unmapped;
      end
   end

   assign axi.axi_arready = w_arready;
   assign axi.axi_rvalid  = (r_rstate == R_DATA);
   assign axi.axi_rdata   = r_rdata;
   assign axi.axi_rresp   = r_rresp;

   // ------------------------------------------------------------------------
   // Fabric-side outputs
   // ------------------------------------------------------------------------
   assign ctrl_out  = r_ctrl;
   assign pulse_out = r_pulse;

   // Byte-lane address bits carry no meaning for 32-bit registers.
   logic w_unused_addr_lsb;
   assign w_unused_addr_lsb = ^{axi.axi_awaddr[1:0], axi.axi_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_slave
// Purpose  : Directed self-checking bench for axi_lite_reg_slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_reg_slave;

   localparam logic [31:0] c_version  = 32'h2025_1122;
   localparam logic [31:0] c_ctrl_rst = 32'h0000_0000;
`ifdef AXIL_SLVERR_EN
   localparam logic [1:0]  c_exp_uresp = 2'b10;
   localparam logic [31:0] c_exp_udata = 32'hDEAD_BEEF;
`else
   localparam logic [1:0]  c_exp_uresp = 2'b00;
   localparam logic [31:0] c_exp_udata = 32'h0000_0000;
`endif

   logic        clk;
   logic        rstn;
   logic [31:0] status_in;
   logic [31:0] ctrl_out;
   logic [31:0] pulse_out;

   int n_vec  = 0;
   int n_miss = 0;
   int exp_wr = 0;

   axi_lite_reg_slave_if #(.ADDR_W(15)) bus ();

   axi_lite_reg_slave #(
      .ADDR_W  (15),
      .VERSION (c_version),
      .CTRL_RST(c_ctrl_rst)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .axi      (bus),
      .status_in(status_in),
      .ctrl_out (ctrl_out),
      .pulse_out(pulse_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full write with both channels presented together; returns pulse_out as
   // seen in the cycle after commit.
   task automatic do_write(input logic [14:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_bresp,
                           output logic [31:0] pulse_seen);
      bit aw_done = 0;
      bit w_done  = 0;
      bit a, w;
      bus.axi_awaddr  = addr;
      bus.axi_wdata   = data;
      bus.axi_wstrb   = strb;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid  = 1'b1;
      bus.axi_bready  = 1'b1;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         @(negedge clk);
         a = bus.axi_awvalid && bus.axi_awready;
         w = bus.axi_wvalid && bus.axi_wready;
         @(posedge clk); #1;
         if (a) begin bus.axi_awvalid = 1'b0; aw_done = 1; end
         if (w) begin bus.axi_wvalid  = 1'b0; w_done  = 1; end
      end
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      chk("wr_accept", {31'd0, aw_done && w_done}, 32'd1);
      chk("wr_bvalid_after_commit", {31'd0, bus.axi_bvalid}, 32'd1);
      chk("wr_bresp", {30'd0, bus.axi_bresp}, {30'd0, exp_bresp});
      pulse_seen = pulse_out;
      exp_wr++;
      @(posedge clk); #1;
      chk("wr_bvalid_drop", {31'd0, bus.axi_bvalid}, 32'd0);
   endtask

   task automatic do_read(input logic [14:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
      bit done = 0;
      bit a;
      bus.axi_araddr  = addr;
      bus.axi_arvalid = 1'b1;
      bus.axi_rready  = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         a = bus.axi_arvalid && bus.axi_arready;
         @(posedge clk); #1;
         if (a) begin bus.axi_arvalid = 1'b0; done = 1; end
      end
      bus.axi_arvalid = 1'b0;
      chk("rd_accept", {31'd0, done}, 32'd1);
      chk("rd_rvalid_latency", {31'd0, bus.axi_rvalid}, 32'd1);
      data = bus.axi_rdata;
      resp = bus.axi_rresp;
      @(posedge clk); #1;
      chk("rd_rvalid_drop", {31'd0, bus.axi_rvalid}, 32'd0);
   endtask

   logic [31:0] rd;
   logic [1:0]  rr;
   logic [31:0] pv;
   logic [31:0] hold_b;
   logic [31:0] hold_r;
   bit          bad_b;
   bit          bad_r;

   initial begin
      rstn            = 1'b0;
      status_in       = 32'h0BAD_F00D;
      bus.axi_awaddr  = '0;
      bus.axi_awvalid = 1'b0;
      bus.axi_wdata   = '0;
      bus.axi_wstrb   = '0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_bready  = 1'b0;
      bus.axi_araddr  = '0;
      bus.axi_arvalid = 1'b0;
      bus.axi_rready  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", {31'd0, bus.axi_awready}, 32'd0);
      chk("rst_wready",  {31'd0, bus.axi_wready},  32'd0);
      chk("rst_arready", {31'd0, bus.axi_arready}, 32'd0);
      chk("rst_bvalid",  {31'd0, bus.axi_bvalid},  32'd0);
      chk("rst_rvalid",  {31'd0, bus.axi_rvalid},  32'd0);
      chk("rst_rdata",   bus.axi_rdata, 32'd0);
      chk("rst_ctrl",    ctrl_out, c_ctrl_rst);
      chk("rst_pulse",   pulse_out, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_awready", {31'd0, bus.axi_awready}, 32'd1);
      chk("post_rst_arready", {31'd0, bus.axi_arready}, 32'd1);

      // VERSION and STATUS
      do_read(15'h0000, rd, rr);
      chk("version_data", rd, c_version);
      chk("version_resp", {30'd0, rr}, 32'd0);
      do_read(15'h0004, rd, rr);
      chk("status_data", rd, 32'h0BAD_F00D);

      // Byte-strobed SCRATCH write: lanes 0 and 2 of A5A5_1234
      do_write(15'h0008, 32'hA5A5_1234, 4'b0101, 2'b00, pv);
      do_read(15'h0008, rd, rr);
      chk("scratch_strb", rd, 32'h00A5_0034);

      // Write to RO VERSION has no effect
      do_write(15'h0000, 32'hFFFF_FFFF, 4'hF, 2'b00, pv);
      do_read(15'h0000, rd, rr);
      chk("version_ro", rd, c_version);

      // W three cycles ahead of AW, to CTRL
      bus.axi_bready = 1'b1;
      bus.axi_wdata  = 32'hCAFE_F00D;
      bus.axi_wstrb  = 4'hF;
      bus.axi_wvalid = 1'b1;
      @(negedge clk);
      chk("early_w_wready", {31'd0, bus.axi_wready}, 32'd1);
      @(posedge clk); #1;
      bus.axi_wvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("early_w_held_wready", {31'd0, bus.axi_wready}, 32'd0);
      chk("early_w_no_bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
      bus.axi_awaddr  = 15'h000C;
      bus.axi_awvalid = 1'b1;
      @(negedge clk);
      chk("late_aw_awready", {31'd0, bus.axi_awready}, 32'd1);
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      exp_wr++;
      chk("ctrl_after_commit", ctrl_out, 32'hCAFE_F00D);
      chk("early_w_bvalid", {31'd0, bus.axi_bvalid}, 32'd1);
      @(posedge clk); #1;
      chk("early_w_single_bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
      do_read(15'h0014, rd, rr);
      chk("wr_count_a", rd, 32'(exp_wr));

      // PULSE: one-cycle strobe, reads back 0
      do_write(15'h0010, 32'h8000_0001, 4'hF, 2'b00, pv);
      chk("pulse_strobe", pv, 32'h8000_0001);
      chk("pulse_cleared", pulse_out, 32'd0);
      do_read(15'h0010, rd, rr);
      chk("pulse_read_zero", rd, 32'd0);

      // Backpressure: bready/rready low for 10 cycles
      bus.axi_bready  = 1'b0;
      bus.axi_rready  = 1'b0;
      bus.axi_awaddr  = 15'h0008;
      bus.axi_wdata   = 32'h1122_3344;
      bus.axi_wstrb   = 4'hF;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid  = 1'b1;
      @(posedge clk); #1;
      exp_wr++;
      // New write offered while the response is pending; must not be taken
      bus.axi_awaddr  = 15'h000C;
      bus.axi_wdata   = 32'hFFFF_0000;
      bus.axi_araddr  = 15'h0008;
      bus.axi_arvalid = 1'b1;
      @(posedge clk); #1;
      bus.axi_arvalid = 1'b0;
      hold_b = {30'd0, bus.axi_bresp};
      hold_r = bus.axi_rdata;
      bad_b  = 0;
      bad_r  = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!bus.axi_bvalid || bus.axi_awready || bus.axi_wready ||
             {30'd0, bus.axi_bresp} != hold_b) bad_b = 1;
         if (!bus.axi_rvalid || bus.axi_arready || bus.axi_rdata != hold_r) bad_r = 1;
      end
      chk("bp_write_stable", {31'd0, bad_b}, 32'd0);
      chk("bp_read_stable", {31'd0, bad_r}, 32'd0);
      chk("bp_read_data", hold_r, 32'h1122_3344);
      chk("bp_ctrl_untouched", ctrl_out, 32'hCAFE_F00D);
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_bready  = 1'b1;
      bus.axi_rready  = 1'b1;
      @(posedge clk); #1;
      chk("bp_bvalid_release", {31'd0, bus.axi_bvalid}, 32'd0);
      chk("bp_rvalid_release", {31'd0, bus.axi_rvalid}, 32'd0);

      // Read accepted on the same cycle as a write commit to the same register
      bus.axi_awaddr  = 15'h0008;
      bus.axi_wdata   = 32'h5566_7788;
      bus.axi_wstrb   = 4'hF;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid  = 1'b1;
      bus.axi_araddr  = 15'h0008;
      bus.axi_arvalid = 1'b1;
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_arvalid = 1'b0;
      exp_wr++;
      chk("same_cycle_rdata", bus.axi_rdata, 32'h1122_3344);
      chk("same_cycle_bvalid", {31'd0, bus.axi_bvalid}, 32'd1);
      @(posedge clk); #1;
      do_read(15'h0008, rd, rr);
      chk("same_cycle_new_value", rd, 32'h5566_7788);

      // Unmapped accesses
      do_read(15'h7FFC, rd, rr);
      chk("unmapped_rdata", rd, c_exp_udata);
      chk("unmapped_rresp", {30'd0, rr}, {30'd0, c_exp_uresp});
      do_write(15'h7FFC, 32'h1234_5678, 4'hF, c_exp_uresp, pv);
      do_read(15'h0014, rd, rr);
      chk("wr_count_b", rd, 32'(exp_wr));
      do_read(15'h0008, rd, rr);
      chk("unmapped_no_effect", rd, 32'h5566_7788);

      // Reset asserted while a response is pending
      bus.axi_bready  = 1'b0;
      bus.axi_awaddr  = 15'h000C;
      bus.axi_wdata   = 32'h1234_5678;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid  = 1'b1;
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      chk("mid_resp_bvalid", {31'd0, bus.axi_bvalid}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("abort_bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
      chk("abort_ctrl", ctrl_out, c_ctrl_rst);
      chk("abort_awready", {31'd0, bus.axi_awready}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      bus.axi_bready = 1'b1;
      @(posedge clk); #1;
      chk("rerst_awready", {31'd0, bus.axi_awready}, 32'd1);
      do_read(15'h0014, rd, rr);
      chk("rerst_wr_count", rd, 32'd0);
      do_read(15'h0008, rd, rr);
      chk("rerst_scratch", rd, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
